// File: rtl/main_memory_ctrl_if.sv
// Cache-side bus for main_memory_ctrl.
// The master is the cache or the testbench. The slave is the controller.
interface main_memory_ctrl_if;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic        memReady;
  logic        memValid;
  logic [31:0] memReadData;
  logic [2:0]  memBeat;
  logic        memDone;

  modport master (
    output memReq, memWe, memAddr, memWriteData,
    input  memReady, memValid, memReadData, memBeat, memDone
  );

  modport slave (
    input  memReq, memWe, memAddr, memWriteData,
    output memReady, memValid, memReadData, memBeat, memDone
  );
endinterface

// File: rtl/main_memory_ctrl.sv
// Main memory model with a fixed access latency.
// A write stores a single word. A read returns a burst of LINE_WORDS words for one line.
// Optional macro MEM_CRITICAL_WORD_FIRST_EN: the read burst starts at the requested word
// and wraps inside the line.
module main_memory_ctrl #(
  parameter int unsigned ADDR_BITS  = 10,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned LINE_WORDS = 4
) (
  input logic               clk,
  input logic               rst,
  main_memory_ctrl_if.slave bus
);
  localparam int unsigned OffBits = $clog2(LINE_WORDS);
  localparam int unsigned Depth   = 1 << ADDR_BITS;

  typedef enum logic [1:0] {StIdle, StWait, StBurst, StWdone} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [OffBits-1:0]   beat_q, beat_d;
  logic                 we_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          mem [Depth];

  logic                 accept;
  logic                 last_beat;
  logic                 mem_wr;
  logic [OffBits-1:0]   word;
  logic [ADDR_BITS-1:0] rd_idx;
  logic                 unused_addr_hi;

  // Address bits above the array index are don't-care.
  assign unused_addr_hi = ^bus.memAddr[31:ADDR_BITS];

  assign accept    = (state_q == StIdle) && bus.memReq;
  assign last_beat = (beat_q == OffBits'(LINE_WORDS - 1));

`ifdef MEM_CRITICAL_WORD_FIRST_EN
  // Adding in OffBits width wraps the word index inside the line.
  assign word = beat_q + addr_q[OffBits-1:0];
`else
  assign word = beat_q;
`endif

  // The line base keeps the upper index bits. The word offset replaces the low bits, so a
  // burst never crosses a line boundary or the top of the array.
  assign rd_idx = {addr_q[ADDR_BITS-1:OffBits], word};

  // State, latency counter and beat counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
    end
  end

  // Latch the request fields on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= bus.memWe;
      addr_q  <= bus.memAddr[ADDR_BITS-1:0];
      wdata_q <= bus.memWriteData;
    end
  end

  // Array write. The array has no reset.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[addr_q] <= wdata_q;
    end
  end

  // Next-state logic and counter updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    mem_wr  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.memReq) begin
          state_d = StWait;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = we_q ? StWdone : StBurst;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StBurst: begin
        if (last_beat) begin
          state_d = StIdle;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + OffBits'(1);
        end
      end
      StWdone: begin
        mem_wr  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs. Read data and beat are held at zero outside a burst.
  always_comb begin
    bus.memReady    = (state_q == StIdle);
    bus.memValid    = (state_q == StBurst);
    bus.memDone     = (state_q == StWdone) || ((state_q == StBurst) && last_beat);
    bus.memReadData = 32'h0;
    bus.memBeat     = 3'h0;
    if (state_q == StBurst) begin
      bus.memReadData = mem[rd_idx];
      bus.memBeat     = 3'(word);
    end
  end
endmodule

// File: tb/tb_main_memory_ctrl.sv
// Directed testbench for main_memory_ctrl with default parameters.
// Each scenario is a task that makes its own checks.
module tb_main_memory_ctrl;
  localparam int unsigned LATENCY    = 4;
  localparam int unsigned LINE_WORDS = 4;

`ifdef MEM_CRITICAL_WORD_FIRST_EN
  localparam bit Cwf = 1'b1;
`else
  localparam bit Cwf = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  main_memory_ctrl_if bus ();

  main_memory_ctrl #(
    .ADDR_BITS (10),
    .LATENCY   (LATENCY),
    .LINE_WORDS(LINE_WORDS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Check the idle outputs expected after a reset.
  task automatic check_idle(input string name);
    checks++;
    if (bus.memReady !== 1'b1 || bus.memValid !== 1'b0 || bus.memDone !== 1'b0 ||
        bus.memReadData !== 32'h0 || bus.memBeat !== 3'h0) begin
      failures++;
      $display("FAIL %s idle outputs: got rdy=%b vld=%b done=%b data=%h beat=%0d, want 1 0 0 0 0",
               name, bus.memReady, bus.memValid, bus.memDone, bus.memReadData, bus.memBeat);
    end
  endtask

  task automatic test_reset();
    bus.memReq = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset");
  endtask

  // Call this with the DUT idle, at a sample point 1 time unit after a rising edge.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input string name);
    int cyc;
    bit seen;
    bus.memReq = 1'b1;
    bus.memWe = 1'b1;
    bus.memAddr = addr;
    bus.memWriteData = data;
    @(posedge clk);
    #1;
    bus.memReq = 1'b0;
    bus.memWe = 1'b0;
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc <= 40) begin
      if (bus.memDone === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    checks++;
    if (!seen || cyc != LATENCY + 1) begin
      failures++;
      $display("FAIL %s write latency: got %0d cycles (done seen=%0b), want %0d", name, cyc, seen,
               LATENCY + 1);
    end
    checks++;
    if (bus.memReady !== 1'b0) begin
      failures++;
      $display("FAIL %s ready with done: got %b, want 0", name, bus.memReady);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.memReady !== 1'b1 || bus.memDone !== 1'b0) begin
      failures++;
      $display("FAIL %s after write: got rdy=%b done=%b, want 1 0", name, bus.memReady,
               bus.memDone);
    end
  endtask

  // line[] holds the words at line offsets 0..3. Expected order depends on the macro.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] l0, input logic [31:0] l1,
                         input logic [31:0] l2, input logic [31:0] l3, input string name);
    logic [31:0] line [4];
    int cyc;
    int w;
    bit seen;
    line[0] = l0;
    line[1] = l1;
    line[2] = l2;
    line[3] = l3;
    bus.memReq = 1'b1;
    bus.memWe = 1'b0;
    bus.memAddr = addr;
    @(posedge clk);
    #1;
    bus.memReq = 1'b0;
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc <= 40) begin
      if (bus.memValid === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    checks++;
    if (!seen || cyc != LATENCY + 1) begin
      failures++;
      $display("FAIL %s read latency: got %0d cycles (valid seen=%0b), want %0d", name, cyc, seen,
               LATENCY + 1);
    end
    for (int k = 0; k < 4; k++) begin
      w = Cwf ? ((int'(addr[1:0]) + k) % 4) : k;
      checks++;
      if (bus.memValid !== 1'b1 || bus.memReadData !== line[w] || bus.memBeat !== 3'(w) ||
          bus.memDone !== (k == 3) || bus.memReady !== 1'b0) begin
        failures++;
        $display("FAIL %s beat %0d: got vld=%b data=%h beat=%0d done=%b rdy=%b, want 1 %h %0d %b 0",
                 name, k, bus.memValid, bus.memReadData, bus.memBeat, bus.memDone,
                 bus.memReady, line[w], w, (k == 3));
      end
      @(posedge clk);
      #1;
    end
    check_idle({name, " end"});
  endtask

  task automatic test_reset_write_read();
    do_write(32'h000, 32'hF0F0F0F0, "wr0");
    do_write(32'h001, 32'h11111111, "wr1");
    do_write(32'h002, 32'h22222222, "wr2");
    do_write(32'h003, 32'h33333333, "wr3");
    do_read(32'h000, 32'hF0F0F0F0, 32'h11111111, 32'h22222222, 32'h33333333, "rd0");
  endtask

  task automatic test_bursts();
    do_write(32'h100, 32'h1, "wr100");
    do_write(32'h101, 32'h2, "wr101");
    do_write(32'h102, 32'h3, "wr102");
    do_write(32'h103, 32'h4, "wr103");
    do_read(32'h102, 32'h1, 32'h2, 32'h3, 32'h4, "rd102");
  endtask

  task automatic test_busy();
    bit overlap;
    bit seen;
    int cyc;
    overlap = 1'b0;
    seen = 1'b0;
    bus.memReq = 1'b1;
    bus.memWe = 1'b0;
    bus.memAddr = 32'h000;
    @(posedge clk);
    #1;
    bus.memAddr = 32'h200;
    cyc = 0;
    while (!seen && cyc < 40) begin
      if (bus.memValid === 1'b1 && bus.memReady === 1'b1) overlap = 1'b1;
      if (bus.memDone === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    checks++;
    if (!seen || bus.memReady !== 1'b0) begin
      failures++;
      $display("FAIL busy first done: got seen=%0b rdy=%b, want 1 0", seen, bus.memReady);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.memReady !== 1'b1) begin
      failures++;
      $display("FAIL busy ready after done: got %b, want 1", bus.memReady);
    end
    @(posedge clk);
    #1;
    bus.memReq = 1'b0;
    checks++;
    if (bus.memReady !== 1'b0) begin
      failures++;
      $display("FAIL busy second accept: got rdy=%b, want 0", bus.memReady);
    end
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 40) begin
      if (bus.memValid === 1'b1 && bus.memReady === 1'b1) overlap = 1'b1;
      if (bus.memDone === 1'b1) seen = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (!seen || overlap) begin
      failures++;
      $display("FAIL busy second op: got done seen=%0b overlap=%0b, want 1 0", seen, overlap);
    end
  endtask

  task automatic test_abort();
    bit done_seen;
    do_write(32'h010, 32'hAAAA5555, "ab0");
    do_write(32'h011, 32'h0B0B0B0B, "ab1");
    do_write(32'h012, 32'h0C0C0C0C, "ab2");
    do_write(32'h013, 32'h0D0D0D0D, "ab3");
    done_seen = 1'b0;
    bus.memReq = 1'b1;
    bus.memWe = 1'b1;
    bus.memAddr = 32'h010;
    bus.memWriteData = 32'h0000DEAD;
    @(posedge clk);
    #1;
    bus.memReq = 1'b0;
    bus.memWe = 1'b0;
    repeat (2) begin
      if (bus.memDone === 1'b1) done_seen = 1'b1;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("abort");
    repeat (10) begin
      if (bus.memDone === 1'b1) done_seen = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (done_seen) begin
      failures++;
      $display("FAIL abort done pulse: got 1, want 0");
    end
    do_read(32'h010, 32'hAAAA5555, 32'h0B0B0B0B, 32'h0C0C0C0C, 32'h0D0D0D0D, "abort rd");
  endtask

  task automatic test_wrap();
    do_write(32'h3FC, 32'hA0A0A0A0, "wrap0");
    do_write(32'h3FD, 32'hA1A1A1A1, "wrap1");
    do_write(32'h3FE, 32'hA2A2A2A2, "wrap2");
    do_write(32'h3FF, 32'hA3A3A3A3, "wrap3");
    do_write(32'h7FC, 32'hB0B0B0B0, "wrap alias");
    do_read(32'h3FF, 32'hB0B0B0B0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, "wrap rd");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.memReq = 1'b0;
    bus.memWe = 1'b0;
    bus.memAddr = 32'h0;
    bus.memWriteData = 32'h0;
    test_reset();
    test_reset_write_read();
    test_bursts();
    test_busy();
    test_abort();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
